// File: rtl/hood_mode_sequencer.sv
// Hood mode sequencer: owns current_mode, edge-detects the user buttons and the
// third-mode toggle, arbitrates simultaneous requests and runs the timed modes
// (THIRD, CLEAN) and the STAND idle timeout.
//
// state  | meaning
// -------+--------------------------------------------------------------
// OFF    | hood powered down; only a power rise is honoured
// STAND  | powered, idle; menu arms gear selection, idle timeout runs
// FIRST  | first gear
// SECOND | second gear
// THIRD  | hurricane mode, timed, once per power-on, drops to SECOND
// CLEAN  | self-clean, timed, only power is honoured, drops to OFF

// Mode encodings normally come from parameters.vh; these defaults keep the
// file self-contained and are skipped when the shared header is present.
`ifndef MODE_WIDTH
`define MODE_WIDTH 3
`endif
`ifndef OFF_MODE
`define OFF_MODE 3'd0
`endif
`ifndef STAND_MODE
`define STAND_MODE 3'd1
`endif
`ifndef FIRST_MODE
`define FIRST_MODE 3'd2
`endif
`ifndef SECOND_MODE
`define SECOND_MODE 3'd3
`endif
`ifndef THIRD_MODE
`define THIRD_MODE 3'd4
`endif
`ifndef CLEAN_MODE
`define CLEAN_MODE 3'd5
`endif

module hood_mode_sequencer #(
    parameter int CNT_W         = 8,
    parameter int THIRD_SECONDS = 60,
    parameter int CLEAN_SECONDS = 180,
    parameter int STAND_TIMEOUT = 30
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   tick_1s,
    input  logic                   power_signal,
    input  logic                   menu_signal,
    input  logic                   first_signal,
    input  logic                   second_signal,
    input  logic                   clean_signal,
    input  logic                   third_toggle,
    output logic [`MODE_WIDTH-1:0] current_mode,
    output logic [CNT_W-1:0]       countdown_sec,
    output logic                   third_used,
    output logic                   mode_changed
);

    typedef enum logic [`MODE_WIDTH-1:0] {
        MODE_OFF    = `OFF_MODE,
        MODE_STAND  = `STAND_MODE,
        MODE_FIRST  = `FIRST_MODE,
        MODE_SECOND = `SECOND_MODE,
        MODE_THIRD  = `THIRD_MODE,
        MODE_CLEAN  = `CLEAN_MODE
    } mode_e;

    // Bit positions inside the button vector.
    localparam int B_POWER  = 0;
    localparam int B_MENU   = 1;
    localparam int B_FIRST  = 2;
    localparam int B_SECOND = 3;
    localparam int B_CLEAN  = 4;
    localparam int B_THIRD  = 5;

    localparam logic [CNT_W-1:0] LOAD_STAND = CNT_W'(STAND_TIMEOUT);
    localparam logic [CNT_W-1:0] LOAD_THIRD = CNT_W'(THIRD_SECONDS);
    localparam logic [CNT_W-1:0] LOAD_CLEAN = CNT_W'(CLEAN_SECONDS);

    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             used_q, used_d;
    logic             armed_q, armed_d;
    logic             changed_q, changed_d;
    logic [5:0]       btn_prev_q, btn_prev_d;

    logic [5:0]       btn_now;
    logic [5:0]       btn_rise;
    logic             timed_mode;
    logic             expire;

    assign btn_now  = {third_toggle, clean_signal, second_signal,
                       first_signal, menu_signal, power_signal};
    assign btn_rise = btn_now & ~btn_prev_q;

    // Next-state: arbitration by priority, then entry loads / timer update.
    always_comb begin
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        used_d     = used_q;
        armed_d    = armed_q;
        btn_prev_d = btn_now;

        timed_mode = (mode_q == MODE_STAND) || (mode_q == MODE_THIRD) ||
                     (mode_q == MODE_CLEAN);
        expire     = timed_mode && tick_1s && (cnt_q == CNT_W'(1));

        if (btn_rise[B_POWER]) begin
            mode_d = (mode_q == MODE_OFF) ? MODE_STAND : MODE_OFF;
        end else if (expire) begin
            mode_d = (mode_q == MODE_THIRD) ? MODE_SECOND : MODE_OFF;
        end else begin
            case (mode_q)
                MODE_STAND: begin
                    if (btn_rise[B_THIRD] && !used_q)
                        mode_d = MODE_THIRD;
                    else if (armed_q && btn_rise[B_SECOND])
                        mode_d = MODE_SECOND;
                    else if (armed_q && btn_rise[B_FIRST])
                        mode_d = MODE_FIRST;
                    else if (armed_q && btn_rise[B_CLEAN])
                        mode_d = MODE_CLEAN;
                    else if (btn_rise[B_MENU])
                        armed_d = 1'b1;
                end
                MODE_FIRST: begin
                    if (btn_rise[B_SECOND])
                        mode_d = MODE_SECOND;
                    else if (btn_rise[B_MENU])
                        mode_d = MODE_STAND;
                end
                MODE_SECOND: begin
                    if (btn_rise[B_FIRST])
                        mode_d = MODE_FIRST;
                    else if (btn_rise[B_MENU])
                        mode_d = MODE_STAND;
                end
                default: ;
            endcase
        end

        // A mode change always reloads the timer, so a coincident tick is lost.
        if (mode_d != mode_q) begin
            armed_d = 1'b0;
            case (mode_d)
                MODE_OFF: begin
                    cnt_d  = '0;
                    used_d = 1'b0;
                end
                MODE_STAND: cnt_d = LOAD_STAND;
                MODE_THIRD: begin
                    cnt_d  = LOAD_THIRD;
                    used_d = 1'b1;
                end
                MODE_CLEAN: cnt_d = LOAD_CLEAN;
                default:    cnt_d = '0;
            endcase
        end else if ((mode_q == MODE_STAND) && (|btn_rise[5:1])) begin
            cnt_d = LOAD_STAND;
        end else if (timed_mode && tick_1s && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        changed_d = (mode_d != mode_q);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_q     <= MODE_OFF;
            cnt_q      <= '0;
            used_q     <= 1'b0;
            armed_q    <= 1'b0;
            changed_q  <= 1'b0;
            btn_prev_q <= '0;
        end else begin
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            used_q     <= used_d;
            armed_q    <= armed_d;
            changed_q  <= changed_d;
            btn_prev_q <= btn_prev_d;
        end
    end

    assign current_mode  = mode_q;
    assign countdown_sec = cnt_q;
    assign third_used    = used_q;
    assign mode_changed  = changed_q;

endmodule

// File: tb/tb_hood_mode_sequencer.sv
// Bench for hood_mode_sequencer: directed vector table, hand-written corner
// sequences, then random levels checked against a behavioural model.
module tb_hood_mode_sequencer;

    localparam int M_OFF = 0, M_STAND = 1, M_FIRST = 2, M_SECOND = 3, M_THIRD = 4, M_CLEAN = 5;
    localparam int T_THIRD = 3, T_CLEAN = 2, T_STAND = 4;

    localparam logic [6:0] PW = 7'h01, MN = 7'h02, F1 = 7'h04, S2 = 7'h08,
                           CL = 7'h10, TH = 7'h20, TK = 7'h40, NONE = 7'h00;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       tick_1s = 1'b0, power_signal = 1'b0, menu_signal = 1'b0, first_signal = 1'b0;
    logic       second_signal = 1'b0, clean_signal = 1'b0, third_toggle = 1'b0;
    logic [2:0] current_mode;
    logic [7:0] countdown_sec;
    logic       third_used, mode_changed;

    int checks = 0;
    int errors = 0;

    hood_mode_sequencer #(
        .CNT_W(8), .THIRD_SECONDS(T_THIRD), .CLEAN_SECONDS(T_CLEAN), .STAND_TIMEOUT(T_STAND)
    ) dut (
        .clk(clk), .rstn(rstn), .tick_1s(tick_1s),
        .power_signal(power_signal), .menu_signal(menu_signal),
        .first_signal(first_signal), .second_signal(second_signal),
        .clean_signal(clean_signal), .third_toggle(third_toggle),
        .current_mode(current_mode), .countdown_sec(countdown_sec),
        .third_used(third_used), .mode_changed(mode_changed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] in;
        int         mode;
        int         cnt;
        int         used;
        int         chg;
    } vec_t;

    vec_t tbl[$];

    // Behavioural reference state.
    int         m_mode, m_cnt, m_used, m_armed, m_chg;
    logic [5:0] m_prev;
    int         load_tbl[6] = '{0, T_STAND, 0, 0, T_THIRD, T_CLEAN};

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input int mode, input int cnt, input int used, input int chg);
        chk($sformatf("%s.mode", nm), int'(current_mode), mode);
        chk($sformatf("%s.cnt", nm), int'(countdown_sec), cnt);
        chk($sformatf("%s.used", nm), int'(third_used), used);
        chk($sformatf("%s.chg", nm), int'(mode_changed), chg);
    endtask

    task automatic set_in(input logic [6:0] v);
        {tick_1s, third_toggle, clean_signal, second_signal, first_signal, menu_signal, power_signal} = v;
    endtask

    task automatic st(input logic [6:0] v);
        set_in(v);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(NONE);
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        m_mode = M_OFF; m_cnt = 0; m_used = 0; m_armed = 0; m_chg = 0; m_prev = '0;
    endtask

    function automatic vec_t mk(input logic [6:0] in, input int mode, input int cnt, input int used, input int chg);
        vec_t v;
        v.in = in; v.mode = mode; v.cnt = cnt; v.used = used; v.chg = chg;
        return v;
    endfunction

    // Model: pick the highest-priority legal event, then apply the mode's entry load.
    task automatic model_step(input logic [6:0] in);
        logic [5:0] r;
        int         nxt;
        bit         tk, expd;
        r      = in[5:0] & ~m_prev;
        m_prev = in[5:0];
        tk     = in[6];
        nxt    = m_mode;
        expd   = tk && (m_cnt == 1) && (load_tbl[m_mode] != 0);
        if (r[0])
            nxt = (m_mode == M_OFF) ? M_STAND : M_OFF;
        else if (expd)
            nxt = (m_mode == M_THIRD) ? M_SECOND : M_OFF;
        else if (m_mode == M_STAND) begin
            if (r[5] && m_used == 0) nxt = M_THIRD;
            else if (m_armed != 0 && r[3]) nxt = M_SECOND;
            else if (m_armed != 0 && r[2]) nxt = M_FIRST;
            else if (m_armed != 0 && r[4]) nxt = M_CLEAN;
            else if (r[1]) m_armed = 1;
        end else if (m_mode == M_FIRST) begin
            if (r[3]) nxt = M_SECOND;
            else if (r[1]) nxt = M_STAND;
        end else if (m_mode == M_SECOND) begin
            if (r[2]) nxt = M_FIRST;
            else if (r[1]) nxt = M_STAND;
        end
        m_chg = (nxt != m_mode) ? 1 : 0;
        if (m_chg != 0) begin
            m_cnt   = load_tbl[nxt];
            m_armed = 0;
            if (nxt == M_OFF) m_used = 0;
            if (nxt == M_THIRD) m_used = 1;
        end else if (m_mode == M_STAND && (|r[5:1])) begin
            m_cnt = T_STAND;
        end else if (tk && m_cnt > 0) begin
            m_cnt = m_cnt - 1;
        end
        m_mode = nxt;
    endtask

    initial begin
        logic [6:0] lv;

        tbl.push_back(mk(PW,      M_STAND,  4, 0, 1));
        tbl.push_back(mk(NONE,    M_STAND,  4, 0, 0));
        tbl.push_back(mk(PW,      M_OFF,    0, 0, 1));
        tbl.push_back(mk(NONE,    M_OFF,    0, 0, 0));
        tbl.push_back(mk(PW,      M_STAND,  4, 0, 1));
        tbl.push_back(mk(NONE,    M_STAND,  4, 0, 0));
        tbl.push_back(mk(F1,      M_STAND,  4, 0, 0));
        tbl.push_back(mk(TK,      M_STAND,  3, 0, 0));
        tbl.push_back(mk(MN,      M_STAND,  4, 0, 0));
        tbl.push_back(mk(NONE,    M_STAND,  4, 0, 0));
        tbl.push_back(mk(F1,      M_FIRST,  0, 0, 1));
        tbl.push_back(mk(NONE,    M_FIRST,  0, 0, 0));
        tbl.push_back(mk(S2,      M_SECOND, 0, 0, 1));
        tbl.push_back(mk(NONE,    M_SECOND, 0, 0, 0));
        tbl.push_back(mk(MN,      M_STAND,  4, 0, 1));
        tbl.push_back(mk(NONE,    M_STAND,  4, 0, 0));
        tbl.push_back(mk(TH|TK,   M_THIRD,  3, 1, 1));
        tbl.push_back(mk(TH,      M_THIRD,  3, 1, 0));
        tbl.push_back(mk(TH|TK,   M_THIRD,  2, 1, 0));
        tbl.push_back(mk(MN,      M_THIRD,  2, 1, 0));
        tbl.push_back(mk(TK,      M_THIRD,  1, 1, 0));
        tbl.push_back(mk(TK,      M_SECOND, 0, 1, 1));
        tbl.push_back(mk(MN,      M_STAND,  4, 1, 1));
        tbl.push_back(mk(TH,      M_STAND,  4, 1, 0));
        tbl.push_back(mk(MN,      M_STAND,  4, 1, 0));
        tbl.push_back(mk(S2|CL,   M_SECOND, 0, 1, 1));
        tbl.push_back(mk(PW,      M_OFF,    0, 0, 1));
        tbl.push_back(mk(NONE,    M_OFF,    0, 0, 0));
        tbl.push_back(mk(MN|F1|TH|TK, M_OFF, 0, 0, 0));

        do_reset();
        chk_all("reset", M_OFF, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            st(tbl[i].in);
            chk_all($sformatf("vec%0d", i), tbl[i].mode, tbl[i].cnt, tbl[i].used, tbl[i].chg);
        end

        // STAND idle timeout with a reload partway through.
        do_reset();
        st(PW);   st(NONE);
        st(TK);   st(TK);
        chk("stand_cnt2", int'(countdown_sec), 2);
        st(MN);
        chk("stand_reload", int'(countdown_sec), 4);
        st(NONE); st(TK); st(TK); st(TK);
        chk_all("stand_last", M_STAND, 1, 0, 0);
        st(TK);
        chk_all("stand_timeout", M_OFF, 0, 0, 1);

        // CLEAN natural expiry.
        st(PW); st(NONE); st(MN); st(NONE); st(CL);
        chk_all("clean_entry", M_CLEAN, 2, 0, 1);
        st(MN|F1|S2|TH);
        chk_all("clean_ignore", M_CLEAN, 2, 0, 0);
        st(TK);
        st(TK);
        chk_all("clean_expire", M_OFF, 0, 0, 1);

        // CLEAN: power and expiring tick together.
        st(PW); st(NONE); st(MN); st(NONE); st(CL); st(TK);
        chk("clean_one", int'(countdown_sec), 1);
        st(PW|TK);
        chk_all("clean_pw_tick", M_OFF, 0, 0, 1);

        // THIRD: power and expiring tick together must go OFF, not SECOND.
        st(NONE); st(PW); st(NONE); st(TH); st(TK); st(TK);
        chk_all("third_one", M_THIRD, 1, 1, 0);
        st(PW|TK);
        chk_all("third_pw_tick", M_OFF, 0, 0, 1);

        // Async reset in the middle of THIRD.
        st(NONE); st(PW); st(NONE); st(TH);
        chk_all("third_pre_rst", M_THIRD, 3, 1, 1);
        #2 rstn = 1'b0;
        #1;
        chk_all("async_rst", M_OFF, 0, 0, 0);
        set_in(NONE);
        @(negedge clk);
        rstn = 1'b1;

        // Random levels against the reference model.
        do_reset();
        lv = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 29) == 0) lv[0] = ~lv[0];
            for (int b = 1; b < 6; b++)
                if ($urandom_range(0, 4) == 0) lv[b] = ~lv[b];
            lv[6] = ($urandom_range(0, 2) == 0);
            model_step(lv);
            st(lv);
            chk_all($sformatf("rnd%0d", c), m_mode, m_cnt, m_used, m_chg);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
